rvc_fetch_aligner: RTL and testbench

//  Sequences 32-bit fetch words into single RISC-V instructions for the compressed decoder stage.

---
 rtl/rvc_fetch_aligner.sv | 104 ++++++++++
 tb/tb_rvc_fetch_aligner.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: splits/stitches 32-bit fetch words into single RISC-V instructions for decode.
module rvc_fetch_aligner #(
    parameter int VLEN = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    output logic            fetch_ready_o,
    input  logic [31:0]     fetch_data_i,
    input  logic [VLEN-1:0] fetch_addr_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [31:0]     instr_o,
    output logic [VLEN-1:0] instr_addr_o,
    output logic            is_compressed_o
);
    typedef enum logic [1:0] {EMPTY, FULL, HI, STITCH} state_t;

    state_t          r_state;
    logic [31:0]     r_word;
    logic [VLEN-1:0] r_addr;
    logic [15:0]     r_half;
    logic [VLEN-1:0] r_half_addr;

    logic            w_lo_c;
    logic            w_hi_c;
    logic            w_refill;
    logic            w_fetch_hs;
    logic            w_instr_hs;
    logic [VLEN-1:0] w_addr_p2;

    assign w_lo_c    = r_word[1:0] != 2'b11;
    assign w_hi_c    = r_word[17:16] != 2'b11;
    assign w_addr_p2 = r_addr + VLEN'(2);

    always_comb begin
        instr_valid_o = 1'b0;
        fetch_ready_o = 1'b0;
        instr_o       = '0;
        instr_addr_o  = '0;
        w_refill      = 1'b0;
        case (r_state)
            EMPTY: fetch_ready_o = 1'b1;
            FULL: begin
                instr_valid_o = 1'b1;
                instr_o       = w_lo_c ? {16'b0, r_word[15:0]} : r_word;
                instr_addr_o  = r_addr;
                w_refill      = !w_lo_c;
            end
            HI: begin
                instr_valid_o = w_hi_c;
                instr_o       = w_hi_c ? {16'b0, r_word[31:16]} : '0;
                instr_addr_o  = w_hi_c ? w_addr_p2 : '0;
                fetch_ready_o = !w_hi_c;
                w_refill      = w_hi_c;
            end
            STITCH: begin
                instr_valid_o = 1'b1;
                instr_o       = {r_word[15:0], r_half};
                instr_addr_o  = r_half_addr;
            end
            default: ;
        endcase
        // last instruction of the word leaves this cycle: accept the next word without a bubble
        if (w_refill) fetch_ready_o = instr_ready_i;
        if (flush_i) begin
            instr_valid_o = 1'b0;
            fetch_ready_o = 1'b0;
        end
    end

    assign is_compressed_o = instr_o[1:0] != 2'b11;
    assign w_fetch_hs      = fetch_valid_i & fetch_ready_o;
    assign w_instr_hs      = instr_valid_o & instr_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= EMPTY;
            r_word      <= '0;
            r_addr      <= '0;
            r_half      <= '0;
            r_half_addr <= '0;
        end else if (flush_i) begin
            r_state <= EMPTY;
            r_half  <= '0;
        end else if (r_state == HI && !w_hi_c) begin
            // upper half starts a 32-bit instr: park it and pull the sequential word
            if (w_fetch_hs) begin
                r_half      <= r_word[31:16];
                r_half_addr <= w_addr_p2;
                r_word      <= fetch_data_i;
                r_addr      <= r_addr + VLEN'(4);
                r_state     <= STITCH;
            end
        end else if (w_fetch_hs) begin
            r_word  <= fetch_data_i;
            r_addr  <= fetch_addr_i & ~VLEN'(3);
            r_state <= fetch_addr_i[1] ? HI : FULL;
        end else if (w_instr_hs) begin
            r_state <= ((r_state == FULL && w_lo_c) || r_state == STITCH) ? HI : EMPTY;
        end
    end
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner: scoreboard bench for the fetch aligner.
module tb_rvc_fetch_aligner;
    typedef struct {
        logic [31:0] i;
        logic [63:0] a;
        logic        c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic        fetch_ready;
    logic [31:0] fetch_data = '0;
    logic [63:0] fetch_addr = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [63:0] instr_addr;
    logic        is_c;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   pop_cyc[$];

    rvc_fetch_aligner #(.VLEN(64)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .fetch_valid_i(fetch_valid), .fetch_ready_o(fetch_ready),
        .fetch_data_i(fetch_data), .fetch_addr_i(fetch_addr),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_addr_o(instr_addr), .is_compressed_o(is_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            checks++;
            pop_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_instr: got %h @%h, none expected", instr, instr_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (instr !== e.i || instr_addr !== e.a || is_c !== e.c) begin
                    errors++;
                    $display("FAIL instr_out: got %h @%h c=%b want %h @%h c=%b", instr, instr_addr, is_c, e.i, e.a, e.c);
                end
            end
        end
    end

    task automatic expect_instr(input logic [31:0] i, input logic [63:0] a, input logic c);
        exp_t e;
        e.i = i; e.a = a; e.c = c;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [63:0] a);
        int n = 0;
        fetch_valid = 1'b1; fetch_data = d; fetch_addr = a;
        @(negedge clk);
        while (!fetch_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!fetch_ready) begin
            checks++; errors++;
            $display("FAIL fetch_timeout: word %h never accepted", d);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d instrs outstanding, want 0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++; $display("FAIL reset_out: got valid=%b instr=%h want 0/0", instr_valid, instr);
        end
        checks++;
        if (fetch_ready !== 1'b1) begin
            errors++; $display("FAIL reset_fetch_ready: got %b want 1", fetch_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_aligned();
        instr_ready = 1'b0;
        expect_instr(32'h4501, 64'h1000, 1'b1);
        expect_instr(32'h4505, 64'h1002, 1'b1);
        send_word(32'h4505_4501, 64'h1000);
        fetch_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h4501 || fetch_ready !== 1'b0) begin
            errors++; $display("FAIL aligned_full: got v=%b %h fr=%b want 1 4501 0", instr_valid, instr, fetch_ready);
        end
        @(posedge clk); #1 instr_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        pop_cyc.delete();
        for (int k = 0; k < 3; k++) expect_instr(32'h13, 64'h2000 + 64'(4 * k), 1'b0);
        for (int k = 0; k < 3; k++) send_word(32'h0000_0013, 64'h2000 + 64'(4 * k));
        fetch_valid = 1'b0;
        wait_drain();
        checks++;
        if (pop_cyc.size() != 3 || pop_cyc[1] - pop_cyc[0] != 1 || pop_cyc[2] - pop_cyc[1] != 1) begin
            errors++; $display("FAIL back_to_back: got %0d instrs, gaps not 1 cycle, want 3 consecutive", pop_cyc.size());
        end
    endtask

    task automatic test_straddle();
        expect_instr(32'h4501, 64'h3000, 1'b1);
        expect_instr(32'h0000_0513, 64'h3002, 1'b0);
        expect_instr(32'h0010, 64'h3006, 1'b1);
        send_word(32'h0513_4501, 64'h3000);
        send_word(32'h0010_0000, 64'h3004);
        fetch_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_unaligned();
        expect_instr(32'h4585, 64'h4002, 1'b1);
        send_word(32'h4585_FFFF, 64'h4002);
        fetch_valid = 1'b0;
        wait_drain();
        expect_instr(32'h0, 64'h8000, 1'b1);
        expect_instr(32'h0, 64'h8002, 1'b1);
        send_word(32'h0, 64'h8000);
        fetch_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_backpressure();
        expect_instr(32'h4501, 64'h5000, 1'b1);
        send_word(32'h0513_4501, 64'h5000);
        fetch_valid = 1'b0;
        wait_drain();
        instr_ready = 1'b0;
        expect_instr(32'h0000_0513, 64'h5002, 1'b0);
        expect_instr(32'h0010, 64'h5006, 1'b1);
        expect_instr(32'h13, 64'h5008, 1'b0);
        send_word(32'h0010_0000, 64'h5004);
        fetch_data = 32'h0000_0013; fetch_addr = 64'h5008;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h0513 || instr_addr !== 64'h5002 || fetch_ready !== 1'b0) begin
                errors++; $display("FAIL stitch_stall: got v=%b %h @%h fr=%b want 1 00000513 @5002 0", instr_valid, instr, instr_addr, fetch_ready);
            end
        end
        @(posedge clk); #1 instr_ready = 1'b1;
        send_word(32'h0000_0013, 64'h5008);
        fetch_valid = 1'b0;
        wait_drain();
    endtask

    task automatic reach_stitch(input logic [63:0] base);
        expect_instr(32'h4501, base, 1'b1);
        send_word(32'h0513_4501, base);
        fetch_valid = 1'b0;
        wait_drain();
        instr_ready = 1'b0;
        send_word(32'h0010_0000, base + 64'h4);
        fetch_valid = 1'b0;
    endtask

    task automatic test_flush();
        instr_ready = 1'b0;
        send_word(32'h4585_FFFF, 64'h6002);
        fetch_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h4585) begin
            errors++; $display("FAIL flush_hi_pre: got v=%b %h want 1 4585", instr_valid, instr);
        end
        @(posedge clk); #1 flush = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || fetch_ready !== 1'b0) begin
            errors++; $display("FAIL flush_hi_same: got v=%b fr=%b want 0 0", instr_valid, fetch_ready);
        end
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL flush_hi_next: got v=%b fr=%b want 0 1", instr_valid, fetch_ready);
        end
        @(posedge clk); #1;
        reach_stitch(64'h7000);
        flush = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || fetch_ready !== 1'b0) begin
            errors++; $display("FAIL flush_stitch_same: got v=%b fr=%b want 0 0", instr_valid, fetch_ready);
        end
        @(posedge clk); #1 flush = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL flush_stitch_next: got v=%b fr=%b want 0 1", instr_valid, fetch_ready);
        end
        @(posedge clk); #1;
        expect_instr(32'h13, 64'h7100, 1'b0);
        send_word(32'h0000_0013, 64'h7100);
        fetch_valid = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        reach_stitch(64'h9000);
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin
            errors++; $display("FAIL reset_mid: got v=%b %h want 0 0", instr_valid, instr);
        end
        @(posedge clk); #1 rst_n = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_valid !== 1'b0 || fetch_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_after: got v=%b fr=%b want 0 1", instr_valid, fetch_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        expect_instr(32'h4501, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        expect_instr(32'h0000_0513, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        expect_instr(32'h0010, 64'h2, 1'b1);
        send_word(32'h0513_4501, 64'hFFFF_FFFF_FFFF_FFFC);
        send_word(32'h0010_0000, 64'h0);
        fetch_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_back_to_back();
        test_straddle();
        test_unaligned();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_wrap();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
